// File: rtl/reg_file_n.sv
// NREGS x WIDTH register bank with masked multi-register writes, sticky wrap flags
// and two combinational read ports; SAT selects wrap-around or saturating inc/dec.
module reg_file_n #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4,
    parameter int SAT   = 0,
    parameter int SW    = $clog2(NREGS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic             E,
    input  logic [NREGS-1:0] RegSel,
    input  logic [2:0]       FunSel,
    input  logic [SW-1:0]    OutASel,
    input  logic [SW-1:0]    OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [NREGS-1:0] Wrap
);

    localparam int HW = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        OP_DEC  = 3'b000,
        OP_INC  = 3'b001,
        OP_LOAD = 3'b010,
        OP_CLR  = 3'b011,
        OP_LDLO = 3'b100,
        OP_LDHI = 3'b101,
        OP_SHL  = 3'b110,
        OP_FCLR = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_wrap;
    logic [WIDTH-1:0] w_nxt  [NREGS];
    logic [NREGS-1:0] w_set;
    logic [WIDTH-1:0] w_rd   [2**SW];

    // Increment that either wraps to zero or sticks at all-ones.
    function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] r);
        if (&r) return (SAT != 0) ? {WIDTH{1'b1}} : '0;
        return r + ONE;
    endfunction

    // Decrement that either wraps to all-ones or sticks at zero.
    function automatic logic [WIDTH-1:0] f_dec(input logic [WIDTH-1:0] r);
        if (r == '0) return (SAT != 0) ? '0 : {WIDTH{1'b1}};
        return r - ONE;
    endfunction

    always_comb begin
        for (int k = 0; k < NREGS; k++) begin
            w_nxt[k] = r_regs[k];
            w_set[k] = 1'b0;
            case (op_e'(FunSel))
                OP_DEC: begin
                    w_nxt[k] = f_dec(r_regs[k]);
                    w_set[k] = (r_regs[k] == '0);
                end
                OP_INC: begin
                    w_nxt[k] = f_inc(r_regs[k]);
                    w_set[k] = &r_regs[k];
                end
                OP_LOAD: w_nxt[k] = I;
                OP_CLR:  w_nxt[k] = '0;
                OP_LDLO: w_nxt[k] = {r_regs[k][WIDTH-1:HW], I[HW-1:0]};
                OP_LDHI: w_nxt[k] = {I[HW-1:0], r_regs[k][HW-1:0]};
                OP_SHL: begin
                    w_nxt[k] = {r_regs[k][WIDTH-2:0], 1'b0};
                    w_set[k] = r_regs[k][WIDTH-1];
                end
                OP_FCLR: w_nxt[k] = r_regs[k];
                default: w_nxt[k] = r_regs[k];
            endcase
        end
    end

    // Register stage: reset wins over any pending write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
            r_wrap <= '0;
        end else if (E) begin
            for (int k = 0; k < NREGS; k++) begin
                if (RegSel[k]) begin
                    r_regs[k] <= w_nxt[k];
                    r_wrap[k] <= (op_e'(FunSel) == OP_FCLR) ? 1'b0 : (r_wrap[k] | w_set[k]);
                end
            end
        end
    end

    // Read table padded to the full select range so out-of-range selects read zero.
    for (genvar j = 0; j < 2**SW; j++) begin : g_rd
        if (j < NREGS) begin : g_reg
            assign w_rd[j] = r_regs[j];
        end else begin : g_zero
            assign w_rd[j] = '0;
        end
    end

    assign OutA = w_rd[OutASel];
    assign OutB = w_rd[OutBSel];
    assign Wrap = r_wrap;

endmodule

// File: doc/reg_file_n.md
# reg_file_n

Parametrised register file that generalises the team's single 16-bit inc/dec/load/clear register into NREGS registers of WIDTH bits. A one-hot write mask lets one operation be applied to several registers in the same cycle. The file adds half-word loads, shift-left, an optional saturating mode, sticky per-register wrap flags and two combinational read ports. It sits between the ALU result bus and the ALU operand inputs, serving as the general-purpose or address register bank.

## Interface
Parameters:
- WIDTH, 16: register width in bits; must be even and at least 2.
- NREGS, 4: number of registers, from 2 to 16.
- SAT, 0: 0 selects wrap-around inc/dec; 1 selects saturating inc/dec.
- SW, $clog2(NREGS): read-select width (derived).

Ports:
- Clock  in  1  sole clock; everything updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- I  in  WIDTH  load data.
- E  in  1  global write enable.
- RegSel  in  NREGS  one-hot-or-multi write mask; bit k targets register k.
- FunSel  in  3  operation code, listed under Operation.
- OutASel  in  SW  read port A select.
- OutBSel  in  SW  read port B select.
- OutA  out  WIDTH  contents of register OutASel.
- OutB  out  WIDTH  contents of register OutBSel.
- Wrap  out  NREGS  sticky per-register overflow/underflow flags.

## Operation
- Write condition for register k: Reset=0, E=1 and RegSel[k]=1. Registers whose write condition is false hold both their value and their flag.
- FunSel codes, applied independently to each selected register R:
  - 000 DEC: R <= R-1.
  - 001 INC: R <= R+1.
  - 010 LOAD: R <= I.
  - 011 CLR: R <= 0. Wrap[k] is unchanged.
  - 100 LDLO: R[WIDTH/2-1:0] <= I[WIDTH/2-1:0]; upper half kept.
  - 101 LDHI: R[WIDTH-1:WIDTH/2] <= I[WIDTH/2-1:0]; lower half kept. The source is the lower half of I.
  - 110 SHL: R <= {R[WIDTH-2:0],1'b0}.
  - 111 FCLR: Wrap[k] <= 0; R unchanged.
- Wrap-around and flag rules:
  - INC at all-ones: SAT=0 gives 0; SAT=1 holds all-ones. Wrap[k] is set in both modes.
  - DEC at 0: SAT=0 gives all-ones; SAT=1 holds 0. Wrap[k] is set in both modes.
  - SHL with R[WIDTH-1]=1 sets Wrap[k].
  - Wrap[k] is sticky. Only FCLR on register k or Reset clears it. No other operation clears it.
- Arithmetic is unsigned modulo 2^WIDTH. No carry into neighbouring registers.
- Read ports:
  - Purely combinational. They show the pre-edge value, with no write-through in the cycle of a write.
  - A select value of NREGS or more drives 0 on that port.
  - Both ports may select the same register.
- Reset:
  - All registers go to 0 and Wrap goes to 0 at the first rising edge with Reset=1.
  - Reset overrides E, RegSel and FunSel, including mid-operation.
- With RegSel all zero, or E=0, the cycle is a full no-op.

## Timing
- Write latency is 1 cycle: the new value is visible on OutA/OutB and Wrap immediately after the edge.
- Read latency is 0 cycles (combinational from OutxSel and register state).
- There is no handshake, no stall and no multi-cycle operation. A new op may be issued every cycle.
- Back-to-back INCs on the same register accumulate: N cycles of INC give R+N mod 2^WIDTH, or saturate when SAT=1.
- Reset values: OutA = OutB = 0 (all registers 0), Wrap = 0.

## Test plan
- Reset, then E=1, RegSel=4'b0101, FunSel=010, I=16'hA5C3 for 1 cycle. Then OutASel=0 and OutBSel=2 both read A5C3; registers 1 and 3 read 0000.
- Wrap mode, SAT=0:
  - Load FFFE into R1, then INC twice. R1 goes FFFF then 0000; Wrap[1] sets on the second INC.
  - Then DEC once. R1=FFFF and Wrap[1] stays 1.
  - Then FCLR. Wrap[1]=0 and R1 is still FFFF.
- Saturating mode, SAT=1:
  - R0=0, DEC 3 cycles. R0 stays 0000 and Wrap[0]=1.
  - Load FFFF, INC. R0 stays FFFF.
- Half loads on R2=1234:
  - LDLO with I=00AB gives R2=12AB.
  - LDHI with I=00CD gives R2=CDAB.
  - SHL gives 9B56 and sets Wrap[2].
- Enable and mask gating: E=0 with RegSel=1111 and FunSel=011 changes nothing. E=1 with RegSel=0000 changes nothing. OutASel=OutBSel=3 returns identical values.
- Reset during ops: INC R3 for 5 cycles with Reset asserted on cycle 3. R3=0 and Wrap=0 after that edge, and counting resumes from 0 on the following cycles.
